// File: rtl/reg_write_scheduler_if.sv
// Bundle of issue, writeback and register-file write-port signals for
// reg_write_scheduler. "slave" is the scheduler side; "master" is the side
// that drives issue and writeback requests (decode, pipeline, long-latency unit).
interface reg_write_scheduler_if;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DATA_W   = 32;

    // Issue from decode
    logic              issue_valid;
    logic              issue_wb_en;
    logic [IDX_W-1:0]  issue_dest;
    logic [IDX_W-1:0]  issue_src1;
    logic [IDX_W-1:0]  issue_src2;
    logic              issue_src1_used;
    logic              issue_src2_used;
    logic              stall;

    // Pipeline writeback (WB0), never back-pressured
    logic              wb0_valid;
    logic [IDX_W-1:0]  wb0_dest;
    logic [DATA_W-1:0] wb0_data;

    // Long-latency unit writeback (WB1), valid/ready handshake
    logic              wb1_valid;
    logic [IDX_W-1:0]  wb1_dest;
    logic [DATA_W-1:0] wb1_data;
    logic              wb1_ready;

    // Register-file write port and scoreboard status
    logic              wr_en;
    logic [IDX_W-1:0]  wr_dest;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_REGS-1:0] busy_vec;
    logic              sched_err;

    modport master (
        output issue_valid, issue_wb_en, issue_dest, issue_src1, issue_src2,
               issue_src1_used, issue_src2_used,
               wb0_valid, wb0_dest, wb0_data,
               wb1_valid, wb1_dest, wb1_data,
        input  stall, wb1_ready, wr_en, wr_dest, wr_data, busy_vec, sched_err
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest, issue_src1, issue_src2,
               issue_src1_used, issue_src2_used,
               wb0_valid, wb0_dest, wb0_data,
               wb1_valid, wb1_dest, wb1_data,
        output stall, wb1_ready, wr_en, wr_dest, wr_data, busy_vec, sched_err
    );
endinterface

// File: rtl/reg_write_scheduler.sv
// Write-port scheduler and per-register pending-write scoreboard for the
// 16x32 register file. Stalls issue on RAW and counter-overflow hazards and
// arbitrates the single write port between WB0 (priority) and WB1.
// Optional feature macro: RF_SCHED_SAME_CYCLE_BYPASS_EN -- lets a source whose
// only pending write retires this cycle be read without stalling, relying on
// the register file's falling-edge write.
module reg_write_scheduler #(
    parameter int unsigned MAX_PENDING = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_write_scheduler_if.slave  bus
);
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CNT_W    = $clog2(MAX_PENDING + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Scoreboard state
    logic [CNT_W-1:0]    pend_q [NUM_REGS];
    logic [CNT_W-1:0]    pend_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                err_q;
    logic                err_d;

    // Combinational write port / handshake
    logic                wr_en_c;
    logic [IDX_W-1:0]    wr_dest_c;
    logic [DATA_W-1:0]   wr_data_c;
    logic                wb1_ready_c;

    // Issue hazard terms
    logic                haz1_c;
    logic                haz2_c;
    logic                full_c;
    logic                stall_c;
    logic                issue_acc_c;

    // One-hot increment / decrement requests per register
    logic [NUM_REGS-1:0] inc_vec_c;
    logic [NUM_REGS-1:0] dec_vec_c;

    // A read of src is blocked while any write to it is outstanding. With the
    // bypass, a single outstanding write that retires this cycle is visible
    // to the read because the register file writes on the falling edge.
    function automatic logic src_hazard(
        input logic             used,
        input logic [IDX_W-1:0] src,
        input logic [CNT_W-1:0] cnt,
        input logic             port_en,
        input logic [IDX_W-1:0] port_dest
    );
        logic blocked;
        blocked = used && (cnt != '0);
`ifdef RF_SCHED_SAME_CYCLE_BYPASS_EN
        if (cnt == CNT_ONE && port_en && port_dest == src) begin
            blocked = 1'b0;
        end
`else
        if (port_en && port_dest == src && 1'b0) begin
            blocked = 1'b0;
        end
`endif
        return blocked;
    endfunction

    // Write-port arbitration: WB0 always wins, WB1 fills idle slots
    always_comb begin
        wr_en_c     = bus.wb0_valid || bus.wb1_valid;
        wb1_ready_c = bus.wb1_valid && !bus.wb0_valid;
        wr_dest_c   = bus.wb1_dest;
        wr_data_c   = bus.wb1_data;
        if (bus.wb0_valid) begin
            wr_dest_c = bus.wb0_dest;
            wr_data_c = bus.wb0_data;
        end
    end

    // Issue hazard detection and acceptance
    always_comb begin
        haz1_c = src_hazard(bus.issue_src1_used, bus.issue_src1,
                            pend_q[bus.issue_src1], wr_en_c, wr_dest_c);
        haz2_c = src_hazard(bus.issue_src2_used, bus.issue_src2,
                            pend_q[bus.issue_src2], wr_en_c, wr_dest_c);
        full_c = bus.issue_wb_en && (pend_q[bus.issue_dest] == CNT_MAX);
        stall_c     = bus.issue_valid && (haz1_c || haz2_c || full_c);
        issue_acc_c = bus.issue_valid && !stall_c;
    end

    // Decode accepted issue and retire into per-register requests
    always_comb begin
        inc_vec_c = '0;
        dec_vec_c = '0;
        if (issue_acc_c && bus.issue_wb_en) begin
            inc_vec_c = NUM_REGS'(1) << bus.issue_dest;
        end
        if (wr_en_c) begin
            dec_vec_c = NUM_REGS'(1) << wr_dest_c;
        end
    end

    // Next counter values; a retire with nothing outstanding flags an error
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_d[i] = pend_q[i];
            if (inc_vec_c[i] && !dec_vec_c[i]) begin
                pend_d[i] = pend_q[i] + CNT_ONE;
            end else if (dec_vec_c[i] && !inc_vec_c[i]) begin
                if (pend_q[i] != '0) begin
                    pend_d[i] = pend_q[i] - CNT_ONE;
                end else begin
                    err_d = 1'b1;
                end
            end
            busy_d[i] = (pend_d[i] != '0);
        end
    end

    // Scoreboard registers, dropped immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                pend_q[i] <= pend_d[i];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign bus.stall     = stall_c;
    assign bus.wb1_ready = wb1_ready_c;
    assign bus.wr_en     = wr_en_c;
    assign bus.wr_dest   = wr_dest_c;
    assign bus.wr_data   = wr_data_c;
    assign bus.busy_vec  = busy_q;
    assign bus.sched_err = err_q;

endmodule
